// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: widths and controller state encoding.
package uart_pkg;

  localparam int unsigned UART_RATIO_W = 8;
  localparam int unsigned UART_DATA_W  = 8;

  // One-hot controller states, same style as the receiver FSM.
  localparam int unsigned UART_ST_W = 3;
  localparam logic [UART_ST_W-1:0] StOff    = 3'b001;
  localparam logic [UART_ST_W-1:0] StArmed  = 3'b010;
  localparam logic [UART_ST_W-1:0] StActive = 3'b100;

  // Increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte stream from the receive controller to the bus-side register block.
interface uart_rx_ctrl_if;

  logic [uart_pkg::UART_DATA_W-1:0] m_data;
  logic                             m_error;
  logic                             m_valid;
  logic                             m_ready;

  modport master (
    output m_data,
    output m_error,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_error,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible combinationally while not empty.
module uart_sync_fifo #(
  parameter  int unsigned WIDTH = 9,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FullLevel);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Occupancy follows the accepted push/pop pair.
  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: owns receiver enable/ratio, buffers bytes, tracks errors and idle timeout.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_enable,
  input  logic [UART_RATIO_W-1:0] cfg_clk_ratio,
  input  logic [7:0]              cfg_timeout,
  input  logic                    clear,
  output logic                    rx_enable,
  output logic [UART_RATIO_W-1:0] rx_clk_ratio,
  input  logic [UART_DATA_W-1:0]  rx_data,
  input  logic                    rx_valid,
  input  logic                    rx_error,
  uart_rx_ctrl_if.master          m,
  output logic [LW-1:0]           level,
  output logic                    overflow,
  output logic [7:0]              err_cnt,
  output logic                    idle_timeout
);

  logic [UART_ST_W-1:0]    state_q, state_d;
  logic [UART_RATIO_W-1:0] ratio_q, ratio_d;
  logic [UART_RATIO_W-1:0] presc_q, presc_d;
  logic [7:0]              bit_q, bit_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              err_q, err_d;
  logic                    bit_tick, hit;
  logic                    fifo_full, fifo_empty, pop, drop;
  logic [UART_DATA_W:0]    head;

  // ---------------------------------------------------------------------------
  // Byte buffer: {error, data}
  // ---------------------------------------------------------------------------
  uart_sync_fifo #(
    .WIDTH (UART_DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_valid),
    .push_data ({rx_error, rx_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign m.m_data  = head[UART_DATA_W-1:0];
  assign m.m_error = head[UART_DATA_W];
  assign m.m_valid = ~fifo_empty;
  assign pop       = ~fifo_empty & m.m_ready;
  assign drop      = rx_valid & fifo_full & ~pop;

  // ---------------------------------------------------------------------------
  // Idle timeout: the pulse fires on the bit tick that brings the bit count to
  // cfg_timeout, i.e. cfg_timeout bit periods after the last byte.
  // ---------------------------------------------------------------------------
  assign bit_tick = (presc_q == ratio_q);
  assign hit      = (state_q == StActive) & cfg_enable & ~rx_valid & bit_tick &
                    (cfg_timeout != 8'd0) &
                    (({1'b0, bit_q} + 9'd1) == {1'b0, cfg_timeout});

  assign idle_timeout = hit;
  assign rx_enable    = (state_q != StOff);
  assign rx_clk_ratio = ratio_q;

  // Controller next state; disable wins over timeout and over a new byte.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOff: begin
        if (cfg_enable) state_d = StArmed;
      end
      StArmed: begin
        if (!cfg_enable)   state_d = StOff;
        else if (rx_valid) state_d = StActive;
      end
      StActive: begin
        if (!cfg_enable) state_d = StOff;
        else if (hit)    state_d = StArmed;
      end
      default: state_d = StOff;
    endcase
  end

  // Ratio tracks the request only while off, so a running frame never sees it change.
  always_comb begin
    ratio_d = (state_q == StOff) ? cfg_clk_ratio : ratio_q;
  end

  // Prescaler and bit counter run only in ACTIVE and restart on every byte.
  always_comb begin
    presc_d = '0;
    bit_d   = '0;
    if ((state_q == StActive) && !rx_valid) begin
      presc_d = bit_tick ? '0 : presc_q + 1'b1;
      bit_d   = bit_tick ? sat_inc8(bit_q) : bit_q;
    end
  end

  // Statistics: an event in the same cycle as clear survives it.
  always_comb begin
    ovf_d = clear ? 1'b0 : ovf_q;
    if (drop) ovf_d = 1'b1;
    err_d = clear ? 8'd0 : err_q;
    if (rx_valid && rx_error) err_d = clear ? 8'd1 : sat_inc8(err_q);
  end

  // Control and statistics state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      ratio_q <= '0;
      presc_q <= '0;
      bit_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ratio_q <= ratio_d;
      presc_q <= presc_d;
      bit_q   <= bit_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign overflow = ovf_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed plus randomized bench for uart_rx_ctrl against a queue-based reference model.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_enable = 1'b0;
  logic [7:0]           cfg_clk_ratio = '0;
  logic [7:0]           cfg_timeout = '0;
  logic                 clear = 1'b0;
  logic                 rx_enable;
  logic [7:0]           rx_clk_ratio;
  logic [7:0]           rx_data = '0;
  logic                 rx_valid = 1'b0;
  logic                 rx_error = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic                 overflow;
  logic [7:0]           err_cnt;
  logic                 idle_timeout;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_enable    (cfg_enable),
    .cfg_clk_ratio (cfg_clk_ratio),
    .cfg_timeout   (cfg_timeout),
    .clear         (clear),
    .rx_enable     (rx_enable),
    .rx_clk_ratio  (rx_clk_ratio),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_error      (rx_error),
    .m             (bus),
    .level         (level),
    .overflow      (overflow),
    .err_cnt       (err_cnt),
    .idle_timeout  (idle_timeout)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [8:0] q[$];
  logic [7:0] popped[$];
  bit         mdl_ovf;
  int         mdl_err;
  bit         mdl_en;
  logic [7:0] mdl_ratio;
  bit         mdl_act;
  int         last_rx;
  int         cyc;
  int         n_pulse;
  int         pulse_cyc;
  int         n_assert = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mdl_ovf   = 0;
    mdl_err   = 0;
    mdl_en    = 0;
    mdl_ratio = '0;
    mdl_act   = 0;
    last_rx   = 0;
  endtask

  // Check the current cycle, advance the model across the clock edge, then the clock.
  task automatic step();
    bit pulse_exp, pop, accept;
    #1;
    pulse_exp = mdl_en && mdl_act && cfg_enable && !rx_valid && (cfg_timeout != 0) &&
                ((cyc - last_rx) == int'(cfg_timeout) * (int'(mdl_ratio) + 1));
    check("rx_enable", 32'(rx_enable), 32'(mdl_en));
    check("rx_clk_ratio", 32'(rx_clk_ratio), 32'(mdl_ratio));
    check("level", 32'(level), 32'(q.size()));
    check("m_valid", 32'(bus.m_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("m_data", 32'(bus.m_data), 32'(q[0][7:0]));
      check("m_error", 32'(bus.m_error), 32'(q[0][8]));
    end
    check("overflow", 32'(overflow), 32'(mdl_ovf));
    check("err_cnt", 32'(err_cnt), 32'(mdl_err));
    check("idle_timeout", 32'(idle_timeout), 32'(pulse_exp));
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) popped.push_back(bus.m_data);
    if (idle_timeout === 1'b1) begin
      n_pulse++;
      pulse_cyc = cyc;
    end
    pop    = (q.size() != 0) && bus.m_ready;
    accept = rx_valid && ((q.size() < DEPTH) || pop);
    if (rx_valid && rx_error) mdl_err = clear ? 1 : ((mdl_err < 255) ? mdl_err + 1 : 255);
    else if (clear)           mdl_err = 0;
    if (clear) mdl_ovf = 0;
    if (rx_valid && !accept) mdl_ovf = 1;
    if (pop) void'(q.pop_front());
    if (accept) q.push_back({rx_error, rx_data});
    if (!mdl_en) begin
      mdl_ratio = cfg_clk_ratio;
      mdl_en    = cfg_enable;
      mdl_act   = 0;
    end else if (!cfg_enable) begin
      mdl_en  = 0;
      mdl_act = 0;
    end else if (pulse_exp) begin
      mdl_act = 0;
    end else if (rx_valid) begin
      mdl_act = 1;
      last_rx = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_error = e;
    step();
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  int r_cyc;
  int base;

  initial begin
    bus.m_ready = 1'b0;
    model_reset();
    cyc = 0;
    n_pulse = 0;
    pulse_cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Reset values
    check("rst rx_enable", 32'(rx_enable), 0);
    check("rst rx_clk_ratio", 32'(rx_clk_ratio), 0);
    check("rst level", 32'(level), 0);
    check("rst m_valid", 32'(bus.m_valid), 0);
    check("rst m_data", 32'(bus.m_data), 0);
    check("rst m_error", 32'(bus.m_error), 0);
    check("rst overflow", 32'(overflow), 0);
    check("rst err_cnt", 32'(err_cnt), 0);
    check("rst idle_timeout", 32'(idle_timeout), 0);

    // Three bytes straight through
    cfg_clk_ratio = 8'd15;
    step();
    cfg_enable = 1'b1;
    step();
    check("enable latency", 32'(rx_enable), 1);
    bus.m_ready = 1'b1;
    popped.delete();
    send(8'h55, 1'b0); step();
    send(8'hA3, 1'b0); step();
    send(8'h0F, 1'b0); steps(2);
    check("pop count", 32'(popped.size()), 3);
    if (popped.size() == 3) begin
      check("pop0", 32'(popped[0]), 32'h55);
      check("pop1", 32'(popped[1]), 32'hA3);
      check("pop2", 32'(popped[2]), 32'h0F);
    end
    check("level drained", 32'(level), 0);

    // Ratio frozen while enabled, follows once off
    cfg_clk_ratio = 8'd7;
    steps(3);
    check("ratio frozen", 32'(rx_clk_ratio), 15);
    cfg_enable = 1'b0;
    steps(2);
    check("ratio follows", 32'(rx_clk_ratio), 7);

    // Overflow with consumer stalled
    cfg_enable = 1'b1;
    bus.m_ready = 1'b0;
    step();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    check("full level", 32'(level), 4);
    check("overflow set", 32'(overflow), 1);
    popped.delete();
    bus.m_ready = 1'b1;
    steps(5);
    check("ovf pop count", 32'(popped.size()), 4);
    for (int i = 0; i < popped.size(); i++) check("ovf pop data", 32'(popped[i]), 32'(i + 1));
    bus.m_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("overflow cleared", 32'(overflow), 0);

    // Push into a full FIFO while popping
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0);
    bus.m_ready = 1'b1;
    send(8'h14, 1'b0);
    check("full push level", 32'(level), 4);
    check("full push no ovf", 32'(overflow), 0);
    steps(5);

    // Error counting, clear coincident with an errored byte, saturation
    send(8'hE0, 1'b1);
    send(8'hE1, 1'b1);
    check("err two", 32'(err_cnt), 2);
    clear = 1'b1;
    send(8'hE2, 1'b1);
    clear = 1'b0;
    check("err clear+event", 32'(err_cnt), 1);
    for (int i = 0; i < 257; i++) send(8'($urandom), 1'b1);
    check("err saturate", 32'(err_cnt), 255);
    steps(3);

    // Idle timeout
    cfg_enable = 1'b0;
    step();
    cfg_clk_ratio = 8'd9;
    cfg_timeout = 8'd3;
    step();
    cfg_enable = 1'b1;
    steps(2);
    n_pulse = 0;
    r_cyc = cyc;
    send(8'h77, 1'b0);
    steps(60);
    check("timeout pulses", 32'(n_pulse), 1);
    check("timeout delay", 32'(pulse_cyc - r_cyc), 30);
    check("armed after timeout", 32'(rx_enable), 1);
    cfg_timeout = 8'd0;
    n_pulse = 0;
    send(8'h78, 1'b0);
    steps(60);
    check("timeout disabled", 32'(n_pulse), 0);

    // Randomized traffic with short timeout
    cfg_enable = 1'b0;
    step();
    cfg_clk_ratio = 8'd1;
    cfg_timeout = 8'd3;
    step();
    cfg_enable = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 400; i++) begin
      rx_valid      = ($urandom_range(3) == 0);
      rx_data       = 8'($urandom);
      rx_error      = ($urandom_range(4) == 0);
      bus.m_ready   = ($urandom_range(2) != 0);
      clear         = ($urandom_range(39) == 0);
      cfg_enable    = ($urandom_range(59) != 0);
      cfg_clk_ratio = 8'($urandom_range(2));
      cfg_timeout   = 8'($urandom_range(3));
      step();
    end
    rx_valid = 1'b0;
    rx_error = 1'b0;
    clear = 1'b0;
    cfg_enable = 1'b1;
    bus.m_ready = 1'b0;
    steps(2);

    // Asynchronous reset mid-operation
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    base = int'(level);
    check("pre-reset level", 32'(base), 32'(q.size()));
    rst_n = 1'b0;
    #1;
    check("async rst level", 32'(level), 0);
    check("async rst m_valid", 32'(bus.m_valid), 0);
    check("async rst rx_enable", 32'(rx_enable), 0);
    cfg_enable = 1'b0;
    cfg_clk_ratio = 8'd0;
    cfg_timeout = 8'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    steps(2);
    cfg_enable = 1'b1;
    bus.m_ready = 1'b1;
    step();
    send(8'h3C, 1'b0);
    steps(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control and buffering stage for the UART receiver. It owns the receiver's `enable` and `clk_ratio` inputs, changes baud configuration only while the receiver is idle, and queues received bytes with their stop-bit error flag in a small FIFO behind a valid/ready port. It also counts framing errors, flags overflow, and signals line-idle timeout, so the bus-side register block deals with a stream rather than single-cycle pulses.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cfg_enable`  in  1  software enable for reception.
- `cfg_clk_ratio`  in  8  requested ratio; one bit period is cfg_clk_ratio+1 clocks.
- `cfg_timeout`  in  8  idle timeout in bit periods; 0 disables it.
- `clear`  in  1  synchronous clear of `overflow` and `err_cnt`.
- `rx_enable`  out  1  to receiver `enable`.
- `rx_clk_ratio`  out  8  to receiver `clk_ratio`.
- `rx_data`  in  8  receiver byte.
- `rx_valid`  in  1  receiver one-cycle byte strobe.
- `rx_error`  in  1  receiver stop-bit error; sampled only when `rx_valid`=1.
- `m_data`  out  8  head byte.
- `m_error`  out  1  error flag of the head byte.
- `m_valid`  out  1  head entry valid.
- `m_ready`  in  1  consumer accept.
- `level`  out  log2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; a byte was dropped.
- `err_cnt`  out  8  saturating count of errored bytes.
- `idle_timeout`  out  1  one-cycle pulse.

## Operation
- The FSM has three states:
  - OFF: `rx_enable`=0; `rx_clk_ratio` loads `cfg_clk_ratio` every cycle. If `cfg_enable`=1, go to ARMED.
  - ARMED: `rx_enable`=1; `rx_clk_ratio` is held. `rx_valid` moves the FSM to ACTIVE. `cfg_enable`=0 moves it to OFF.
  - ACTIVE: `rx_enable`=1; the timeout counter runs. `cfg_enable`=0 moves the FSM to OFF, and takes priority over timeout.
- Timeout counter:
  - A prescaler counts 0..`rx_clk_ratio`; each wrap is one bit tick.
  - The bit counter increments on each bit tick.
  - `rx_valid` resets both counters to 0.
  - When the bit counter equals `cfg_timeout` (non-zero), `idle_timeout` pulses and the FSM returns to ARMED.
- `rx_valid` is accepted in every state, including OFF, because the receiver completes a frame already in flight.
- Push: when `rx_valid`=1, write {`rx_error`, `rx_data`} to the tail if there is space. A push into a full FIFO is allowed when a pop occurs in the same cycle.
- If there is no space, the byte is dropped and `overflow` is set.
- Pop: when `m_valid` & `m_ready`. The FIFO is show-ahead: `m_data` and `m_error` are combinational from the head entry.
- `err_cnt` increments on `rx_valid` & `rx_error`, including dropped bytes, and saturates at 255.
- `clear` zeroes `overflow` and `err_cnt`. An event in the same cycle as `clear` is still recorded: the flag ends at 1, or the count ends at 1. `clear` does not flush the FIFO.
- Pointers use log2(DEPTH) bits and wrap naturally. `level` is the registered occupancy counter.

## Timing
- Reset values:
  - FSM in OFF.
  - `rx_enable`=0, `rx_clk_ratio`=0.
  - `level`=0, `m_valid`=0, `m_data`=0, `m_error`=0.
  - `overflow`=0, `err_cnt`=0, `idle_timeout`=0.
  - Counters and pointers at 0.
- Latency:
  - `rx_valid` at cycle t gives `m_valid`=1 at t+1.
  - `cfg_enable` rising at t gives `rx_enable`=1 at t+1.
  - `rx_clk_ratio` follows `cfg_clk_ratio` with 1 cycle of latency while in OFF, and freezes from the first ARMED cycle.
- For a pop at cycle t, the next entry is visible at t+1.
- `idle_timeout` is asserted for exactly one cycle. It cannot reassert until the FSM has passed through ACTIVE again.
- Reset asserted mid-operation discards FIFO contents immediately (asynchronous). No output glitches after reset is released.

## Structure
- Package `uart_pkg`:
  - FSM state encoding (OFF/ARMED/ACTIVE, one-hot, matching the receiver FSM style).
  - `UART_RATIO_W`=8.
  - `UART_DATA_W`=8.
- Sub-module `uart_sync_fifo` (parameters: width, depth): show-ahead FIFO with full, empty and level outputs. Reusable later by the TX path.
- The controller holds the FSM, the timeout counters and the statistics logic.

## Test plan
- `cfg_clk_ratio`=15, enable, then three bytes 0x55/0xA3/0x0F, with `m_ready`=1. Expect three pops in order, `m_error`=0, `level` returning to 0.
- Enable with `cfg_clk_ratio`=15, then drive `cfg_clk_ratio`=7. Expect `rx_clk_ratio` to stay 15; disable and expect it to become 7 one cycle later.
- `DEPTH`=4, `m_ready`=0, five bytes 0x01–0x05. Expect `level`=4, `overflow`=1, and pops returning 0x01–0x04 only. Then `clear` → `overflow`=0.
- Push while full in the same cycle as a pop. Expect the byte accepted, `level` staying 4, `overflow`=0.
- Two bytes with `rx_error`=1, then `clear` in the same cycle as a third errored byte. Expect `err_cnt`=2 then 1; 257 errored bytes without `clear` → `err_cnt`=255.
- `cfg_timeout`=3, `cfg_clk_ratio`=9, one byte, then an idle line. Expect `idle_timeout` to pulse once 30 clocks after `rx_valid`, and the FSM back in ARMED. `cfg_timeout`=0 → no pulse.
